arbitro_comparador_6bit: RTL

- Shares one 6-bit set-membership comparator (6-bit operand in, 1-bit "belongs to the set" out) between N requesters.
- Grants are round-robin. The block latches the winner's operand, drives the comparator, registers its answer and returns it with a one-cycle Listo pulse.
- Also keeps a saturating count of positive answers.
- Sits between the requesting units and the single comparator instance.

---
 rtl/arbitro_comparador_6bit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/arbitro_comparador_6bit.sv
// Round-robin arbiter that shares one 6-bit set-membership comparator between N requesters.
// It also keeps a saturating count of positive answers.
module arbitro_comparador_6bit #(
  parameter int N          = 4,
  parameter int ANCHO_CONT = 16
) (
  input  logic                  Reloj,
  input  logic                  Reset_n,
  input  logic [N-1:0]          Solicitud,
  input  logic [6*N-1:0]        Dato,
  output logic [N-1:0]          Concedido,
  output logic                  Listo,
  output logic                  Resultado,
  output logic [5:0]            OperandoComparador,
  input  logic                  SalidaComparador,
  output logic [ANCHO_CONT-1:0] ContadorAciertos
);

  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int PW1 = PW + 1;
  localparam logic [N-1:0] UNO_N = N'(1);

  // state     | meaning
  // LIBRE     | idle, arbitrating among pending requests
  // CONSULTA  | operand on comparator, capturing its answer
  // RESPUESTA | Listo and grant visible for one cycle
  typedef enum logic [1:0] {
    LIBRE     = 2'd0,
    CONSULTA  = 2'd1,
    RESPUESTA = 2'd2
  } estado_t;

  estado_t               r_estado, w_estado_sig;
  logic [PW-1:0]         r_puntero, w_puntero_sig;
  logic [PW-1:0]         r_idx, w_idx_sig;
  logic [N-1:0]          r_concedido, w_concedido_sig;
  logic                  r_listo, w_listo_sig;
  logic                  r_resultado, w_resultado_sig;
  logic [5:0]            r_operando, w_operando_sig;
  logic [ANCHO_CONT-1:0] r_contador, w_contador_sig;

  logic [5:0]            w_dato [N];
  logic                  w_hay;
  logic [PW-1:0]         w_sel;
  logic [PW:0]           w_pos;

  for (genvar g = 0; g < N; g++) begin : g_dato
    assign w_dato[g] = Dato[6*g +: 6];
  end

  // Search starts at the pointer and wraps at N-1, so N need not be a power of two.
  always_comb begin
    w_hay = 1'b0;
    w_sel = '0;
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, r_puntero} + PW1'(k);
      if (w_pos >= PW1'(N)) begin
        w_pos = w_pos - PW1'(N);
      end
      if (!w_hay && Solicitud[w_pos[PW-1:0]]) begin
        w_hay = 1'b1;
        w_sel = w_pos[PW-1:0];
      end
    end
  end

  always_comb begin
    w_estado_sig    = r_estado;
    w_puntero_sig   = r_puntero;
    w_idx_sig       = r_idx;
    w_concedido_sig = r_concedido;
    w_listo_sig     = r_listo;
    w_resultado_sig = r_resultado;
    w_operando_sig  = r_operando;
    w_contador_sig  = r_contador;
    case (r_estado)
      LIBRE: begin
        w_concedido_sig = '0;
        w_listo_sig     = 1'b0;
        if (w_hay) begin
          w_idx_sig       = w_sel;
          w_concedido_sig = UNO_N << w_sel;
          w_operando_sig  = w_dato[w_sel];
          w_estado_sig    = CONSULTA;
        end
      end
      CONSULTA: begin
        w_resultado_sig = SalidaComparador;
        w_listo_sig     = 1'b1;
        if (SalidaComparador && !(&r_contador)) begin
          w_contador_sig = r_contador + ANCHO_CONT'(1);
        end
        w_estado_sig = RESPUESTA;
      end
      RESPUESTA: begin
        w_listo_sig     = 1'b0;
        w_concedido_sig = '0;
        w_puntero_sig   = (r_idx == PW'(N-1)) ? '0 : r_idx + PW'(1);
        w_estado_sig    = LIBRE;
      end
      default: begin
        w_estado_sig = LIBRE;
      end
    endcase
  end

  always_ff @(posedge Reloj) begin
    if (!Reset_n) begin
      r_estado    <= LIBRE;
      r_puntero   <= '0;
      r_idx       <= '0;
      r_concedido <= '0;
      r_listo     <= 1'b0;
      r_resultado <= 1'b0;
      r_operando  <= '0;
      r_contador  <= '0;
    end else begin
      r_estado    <= w_estado_sig;
      r_puntero   <= w_puntero_sig;
      r_idx       <= w_idx_sig;
      r_concedido <= w_concedido_sig;
      r_listo     <= w_listo_sig;
      r_resultado <= w_resultado_sig;
      r_operando  <= w_operando_sig;
      r_contador  <= w_contador_sig;
    end
  end

  assign Concedido          = r_concedido;
  assign Listo              = r_listo;
  assign Resultado          = r_resultado;
  assign OperandoComparador = r_operando;
  assign ContadorAciertos   = r_contador;

endmodule
